// File: rtl/clint_timer_pkg.sv
// rtl/clint_timer_pkg.sv - CLINT register offsets, FSM states and byte-strobe merge helper
package clint_timer_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;
  localparam logic [63:0] WINDOW_SIZE  = 64'h0000_0000_0001_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  wstrb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mtime_cnt.sv
// rtl/clint_mtime_cnt.sv - prescaled 64-bit mtime counter with load priority over tick
module clint_mtime_cnt #(
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [63:0] load_data_i,
  output logic [63:0] mtime_o,
  output logic        tick_o
);

  localparam logic [15:0] DIV_LAST = 16'(MTIME_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;

  assign tick_o = (presc_q == DIV_LAST);

  // A load drops the coincident increment; the prescaler keeps its own pace.
  always_comb begin
    presc_d = tick_o ? 16'd0 : presc_q + 16'd1;
    mtime_d = mtime_q;
    if (load_i)      mtime_d = load_data_i;
    else if (tick_o) mtime_d = mtime_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= 16'd0;
      mtime_q <= 64'd0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - CLINT msip/mtimecmp/mtime registers behind a single-outstanding req/resp port
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        clint_mtip,
  output logic        clint_msip
);

  state_e      state_q, state_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        mtip_q;
  logic        mtime_load;
  logic [63:0] mtime;
  logic        tick_unused;
  logic        unused_addr_bits;

  logic [60:0] off_dw;
  logic        hit_msip, hit_cmp, hit_mtime, hit_any;
  logic [63:0] rd_value, wr_merged;

  // Decode at doubleword granularity; addresses below the base wrap to a miss.
  assign off_dw           = req_addr[63:3] - BASE_ADDR[63:3];
  assign unused_addr_bits = ^req_addr[2:0];
  assign hit_msip         = (off_dw == {48'd0, MSIP_OFF[15:3]});
  assign hit_cmp          = (off_dw == {48'd0, MTIMECMP_OFF[15:3]});
  assign hit_mtime        = (off_dw == {48'd0, MTIME_OFF[15:3]});
  assign hit_any          = hit_msip | hit_cmp | hit_mtime;

  assign rd_value  = hit_msip  ? {63'd0, msip_q} :
                     hit_cmp   ? mtimecmp_q      :
                     hit_mtime ? mtime           : 64'd0;
  assign wr_merged = strb_merge(rd_value, req_wdata, req_wstrb);

  assign req_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = RESP;
          err_d   = !hit_any;
          rdata_d = (req_write || !hit_any) ? 64'd0 : rd_value;
          if (req_write) begin
            if (hit_msip)  msip_d     = wr_merged[0];
            if (hit_cmp)   mtimecmp_d = wr_merged;
            if (hit_mtime) mtime_load = 1'b1;
          end
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (mtime >= mtimecmp_q);
    end
  end

  clint_mtime_cnt #(.MTIME_DIV(MTIME_DIV)) u_mtime_cnt (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (mtime_load),
    .load_data_i (wr_merged),
    .mtime_o     (mtime),
    .tick_o      (tick_unused)
  );

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign clint_mtip = mtip_q;
  assign clint_msip = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - self-checking bench for clint_timer against an arithmetic timer model
module tb_clint_timer;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        clint_mtip, clint_msip;

  always #5 clk = ~clk;

  clint_timer #(.BASE_ADDR(BASE), .MTIME_DIV(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .clint_mtip (clint_mtip),
    .clint_msip (clint_msip)
  );

  int errors = 0;
  int checks = 0;

  // Edges since the last reset edge; with MTIME_DIV=1 mtime advances once per edge.
  longint edge_cnt;
  always @(posedge clk) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  logic [63:0] mt_base;
  longint      mt_base_e;
  logic [63:0] cmp_m;
  logic        msip_m;

  function automatic logic [63:0] mt_at(input longint e);
    return mt_base + 64'(e - mt_base_e);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] wd,
                                        input logic [7:0] st);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic int reg_of(input logic [63:0] addr);
    logic [63:0] a;
    a = addr & ~64'h7;
    if (a == BASE)              return 0;
    if (a == BASE + 64'h4000)   return 1;
    if (a == BASE + 64'hBFF8)   return 2;
    return 3;
  endfunction

  task automatic model_reset();
    mt_base   = 64'd0;
    mt_base_e = 0;
    cmp_m     = '1;
    msip_m    = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || clint_mtip !== 1'b0 || clint_msip !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: resp_valid=%b mtip=%b msip=%b want 0 0 0",
               resp_valid, clint_mtip, clint_msip);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    logic exp_tip;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      exp_tip = (mt_at(edge_cnt - 1) >= cmp_m);
      checks++;
      if (clint_mtip !== exp_tip || clint_msip !== msip_m) begin
        errors++;
        $display("FAIL idle_irq: edge=%0d mtip=%b want %b msip=%b want %b",
                 edge_cnt, clint_mtip, exp_tip, clint_msip, msip_m);
      end
    end
  endtask

  task automatic xact(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                      input logic [7:0] st, input int hold, output logic [63:0] rd_o);
    logic [63:0] exp_rd;
    logic        exp_err;
    longint      e;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_wstrb  = st;
    resp_ready = (hold == 0);
    for (int k = 0; k < 4 && req_ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_timeout: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    e         = edge_cnt;
    req_valid = 1'b0;
    exp_rd    = 64'd0;
    exp_err   = 1'b0;
    case (reg_of(addr))
      0: if (wr) begin if (st[0]) msip_m = wd[0]; end else exp_rd = {63'd0, msip_m};
      1: if (wr) cmp_m = merge(cmp_m, wd, st); else exp_rd = cmp_m;
      2: if (wr) begin
           mt_base   = merge(mt_at(e - 1), wd, st);
           mt_base_e = e;
         end else exp_rd = mt_at(e - 1);
      default: exp_err = 1'b1;
    endcase
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_err !== exp_err) begin
      errors++;
      $display("FAIL resp: addr=%h wr=%b valid=%b rdata=%h err=%b want 1 %h %b",
               addr, wr, resp_valid, resp_rdata, resp_err, exp_rd, exp_err);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL resp_hold: valid=%b rdata=%h req_ready=%b want 1 %h 0",
                 resp_valid, resp_rdata, req_ready, exp_rd);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL resp_drop: valid=%b want 0", resp_valid);
    end
    rd_o = resp_rdata;
    rd_o = exp_rd;
  endtask

  task automatic test_reset();
    logic [63:0] rd;
    idle(10);
    xact(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 0, rd);
  endtask

  task automatic test_mtimecmp();
    logic [63:0] rd;
    xact(1'b1, BASE + 64'h4000, 64'd20, 8'hFF, 0, rd);
    idle(25);
    xact(1'b1, BASE + 64'h4000, 64'd1000, 8'hFF, 0, rd);
    checks++;
    if (clint_mtip !== 1'b0) begin
      errors++; $display("FAIL mtip_clear: got %b want 0", clint_mtip);
    end
    idle(2);
  endtask

  task automatic test_wrap();
    logic [63:0] rd;
    logic        seen;
    xact(1'b1, BASE + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd);
    xact(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd);
    seen = clint_mtip;
    idle(1);
    seen = seen | clint_mtip;
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL wrap_mtip_seen: got %b want 1", seen);
    end
    idle(3);
    xact(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 0, rd);
    checks++;
    if (rd > 64'd20) begin
      errors++; $display("FAIL wrap_mtime: got %h want small value after wrap", rd);
    end
  endtask

  task automatic test_msip();
    logic [63:0] rd;
    xact(1'b1, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd);
    checks++;
    if (clint_msip !== 1'b1) begin
      errors++; $display("FAIL msip_out: got %b want 1", clint_msip);
    end
    xact(1'b0, BASE, 64'd0, 8'h00, 0, rd);
  endtask

  task automatic test_partial();
    logic [63:0] rd;
    do_reset();
    xact(1'b1, BASE + 64'h4000, 64'h1234_5678_DEAD_BEEF, 8'h0F, 0, rd);
    xact(1'b0, BASE + 64'h4000, 64'd0, 8'h00, 0, rd);
    checks++;
    if (rd !== 64'hFFFF_FFFF_DEAD_BEEF) begin
      errors++; $display("FAIL partial_model: got %h want FFFFFFFFDEADBEEF", rd);
    end
  endtask

  task automatic test_error();
    logic [63:0] rd;
    xact(1'b0, BASE + 64'h0100, 64'd0, 8'h00, 0, rd);
    xact(1'b1, BASE + 64'h0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd);
    xact(1'b1, BASE + 64'h1_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd);
    xact(1'b0, BASE, 64'd0, 8'h00, 0, rd);
    xact(1'b0, BASE + 64'h4000, 64'd0, 8'h00, 0, rd);
    xact(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 0, rd);
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_rd;
    do_reset();
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = BASE + 64'h4000;
    req_wdata  = 64'd0;
    req_wstrb  = 8'h00;
    resp_ready = 1'b0;
    exp_rd     = cmp_m;
    @(posedge clk); #1;
    req_write = 1'b1;
    req_addr  = BASE;
    req_wdata = 64'd1;
    req_wstrb = 8'h01;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || req_ready !== 1'b0 || clint_msip !== 1'b0) begin
        errors++;
        $display("FAIL stall: valid=%b rdata=%h req_ready=%b msip=%b want 1 %h 0 0",
                 resp_valid, resp_rdata, req_ready, clint_msip, exp_rd);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || clint_msip !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: valid=%b req_ready=%b msip=%b want 0 1 0",
               resp_valid, req_ready, clint_msip);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    msip_m    = 1'b1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'd0 || clint_msip !== 1'b1) begin
      errors++;
      $display("FAIL second_accept: valid=%b rdata=%h msip=%b want 1 0 1",
               resp_valid, resp_rdata, clint_msip);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_resp();
    logic [63:0] rd;
    xact(1'b1, BASE + 64'h4000, 64'd5, 8'hFF, 0, rd);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = BASE + 64'h4000;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'd5) begin
      errors++; $display("FAIL pre_reset_resp: valid=%b rdata=%h want 1 5", resp_valid, resp_rdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 64'd0) begin
      errors++; $display("FAIL reset_in_resp: valid=%b rdata=%h want 0 0", resp_valid, resp_rdata);
    end
    rst        = 1'b0;
    resp_ready = 1'b1;
    model_reset();
    xact(1'b0, BASE + 64'h4000, 64'd0, 8'h00, 0, rd);
    idle(2);
  endtask

  task automatic test_random();
    logic [63:0] addrs [7];
    logic [63:0] rd, wd;
    addrs[0] = BASE;
    addrs[1] = BASE + 64'h4000;
    addrs[2] = BASE + 64'hBFF8;
    addrs[3] = BASE + 64'h0100;
    addrs[4] = BASE + 64'h4005;
    addrs[5] = BASE + 64'h1_0000;
    addrs[6] = BASE - 64'd8;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) wd = {$urandom, $urandom};
      else                           wd = 64'($urandom_range(0, 400));
      xact(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 6)], wd,
           8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), rd);
      idle(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    req_write = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    req_wstrb = 8'h00;
    do_reset();
    test_reset();
    test_mtimecmp();
    test_wrap();
    test_msip();
    test_partial();
    test_error();
    test_back_to_back();
    test_reset_in_resp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
